// File: rtl/rbs_pkg.sv
// Shared types and helpers for the record buffer sequencer.
// Holds the sequencer state encoding and the elaboration-time width helper.
package rbs_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_N_BUF = 6;

   // Smallest width able to index v distinct values.
   function automatic int clog2(input int v);
      int w;
      w = 0;
      while ((1 << w) < v) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/rbs_holdoff.sv
// Loadable down-counter used to ignore pulses for a while after an accepted one.
// expired is high whenever the count has reached zero.
module rbs_holdoff #(
   parameter int HOLD_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [HOLD_W-1:0] load_val,
   output logic              expired
);

   logic [HOLD_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/record_buffer_sequencer.sv
// Walks an active index across N_BUF record buffers and emits a one-hot stop
// strobe once the current buffer has seen the programmed number of pulses.
module record_buffer_sequencer
   import rbs_pkg::*;
#(
   parameter int N_BUF  = DEF_N_BUF,
   parameter int IDX_W  = 3,
   parameter int CNT_W  = 8,
   parameter int HOLD_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_rec,
   input  logic              abort,
   input  logic              pulse,
   input  logic [CNT_W-1:0]  cfg_ppb,
   input  logic              cfg_wrap,
   input  logic [HOLD_W-1:0] cfg_holdoff,
   output logic [N_BUF-1:0]  stop_pulse,
   output logic [IDX_W-1:0]  cur_buf,
   output logic              busy,
   output logic              done,
   output logic              wrapped,
   output logic              dropped,
   output state_t            fsm_state
);

   generate
      if (IDX_W < clog2(N_BUF)) begin : g_bad_idx_w
         $error("IDX_W too small for N_BUF");
      end
   endgenerate

   // Handshake note: pulse, start_rec and abort are plain level strobes sampled
   // on every rising edge; there is no ready back-pressure on any input.

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [IDX_W-1:0]   cur_n;
   logic [CNT_W-1:0]   ppb_q, ppb_n;
   logic               wrap_q, wrap_n;
   logic [HOLD_W-1:0]  hold_q, hold_n;
   logic [N_BUF-1:0]   stop_q, stop_n;
   logic               wrapped_n, dropped_n;
   logic               ho_load;
   logic [HOLD_W-1:0]  ho_val;
   logic               ho_expired;
   logic               last_pulse;
   logic               last_buf;

   rbs_holdoff #(.HOLD_W(HOLD_W)) u_holdoff (
      .clk      (clk),
      .reset    (reset),
      .load     (ho_load),
      .load_val (ho_val),
      .expired  (ho_expired)
   );

   assign last_pulse = (({1'b0, cnt} + 1'b1) == {1'b0, ppb_q});
   assign last_buf   = (cur_buf == IDX_W'(N_BUF - 1));

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      cur_n     = cur_buf;
      ppb_n     = ppb_q;
      wrap_n    = wrap_q;
      hold_n    = hold_q;
      stop_n    = '0;
      wrapped_n = wrapped;
      dropped_n = dropped;
      ho_load   = 1'b0;
      ho_val    = hold_q;

      if (abort) begin
         state_n = IDLE;
         cnt_n   = '0;
         cur_n   = '0;
         ho_load = 1'b1;
         ho_val  = '0;
      end else if (start_rec) begin
         state_n   = RUN;
         ppb_n     = (cfg_ppb == '0) ? CNT_W'(1) : cfg_ppb;
         wrap_n    = cfg_wrap;
         hold_n    = cfg_holdoff;
         cnt_n     = '0;
         cur_n     = '0;
         wrapped_n = 1'b0;
         dropped_n = 1'b0;
         ho_load   = 1'b1;
         ho_val    = '0;
      end else if ((state == RUN) && pulse) begin
         if (ho_expired) begin
            ho_load = 1'b1;
            ho_val  = hold_q;
            if (last_pulse) begin
               stop_n = {{(N_BUF-1){1'b0}}, 1'b1} << cur_buf;
               cnt_n  = '0;
               if (!last_buf) begin
                  cur_n = cur_buf + 1'b1;
               end else if (wrap_q) begin
                  cur_n     = '0;
                  wrapped_n = 1'b1;
               end else begin
                  state_n = DONE;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end else begin
            dropped_n = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         cur_buf <= '0;
         ppb_q   <= CNT_W'(1);
         wrap_q  <= 1'b0;
         hold_q  <= '0;
         stop_q  <= '0;
         wrapped <= 1'b0;
         dropped <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         cur_buf <= cur_n;
         ppb_q   <= ppb_n;
         wrap_q  <= wrap_n;
         hold_q  <= hold_n;
         stop_q  <= stop_n;
         wrapped <= wrapped_n;
         dropped <= dropped_n;
      end
   end

   // A strobe already loaded for this cycle is killed by reset/abort/restart
   // arriving in the same cycle, so the buffer is never stopped after a cancel.
   assign stop_pulse = stop_q & ~{N_BUF{reset | abort | start_rec}};
   assign busy       = (state == RUN);
   assign done       = (state == DONE);
   assign fsm_state  = state;

endmodule

// File: tb/tb_record_buffer_sequencer.sv
// Directed bench for record_buffer_sequencer: expected stop strobes are queued
// with their due cycle and a negedge monitor pops and compares them.
module tb_record_buffer_sequencer;
   import rbs_pkg::*;

   localparam int N_BUF  = 6;
   localparam int IDX_W  = 3;
   localparam int CNT_W  = 8;
   localparam int HOLD_W = 8;

   logic              clk;
   logic              reset;
   logic              start_rec;
   logic              abort;
   logic              pulse;
   logic [CNT_W-1:0]  cfg_ppb;
   logic              cfg_wrap;
   logic [HOLD_W-1:0] cfg_holdoff;
   logic [N_BUF-1:0]  stop_pulse;
   logic [IDX_W-1:0]  cur_buf;
   logic              busy;
   logic              done;
   logic              wrapped;
   logic              dropped;
   state_t            fsm_state;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic [31:0] exp_q[$];   // {due_cycle[25:0], stop_value[5:0]}

   record_buffer_sequencer #(
      .N_BUF(N_BUF), .IDX_W(IDX_W), .CNT_W(CNT_W), .HOLD_W(HOLD_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start_rec   (start_rec),
      .abort       (abort),
      .pulse       (pulse),
      .cfg_ppb     (cfg_ppb),
      .cfg_wrap    (cfg_wrap),
      .cfg_holdoff (cfg_holdoff),
      .stop_pulse  (stop_pulse),
      .cur_buf     (cur_buf),
      .busy        (busy),
      .done        (done),
      .wrapped     (wrapped),
      .dropped     (dropped),
      .fsm_state   (fsm_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic step(input logic s, input logic a, input logic p);
      start_rec = s;
      abort     = a;
      pulse     = p;
      @(posedge clk);
      #1;
      start_rec = 1'b0;
      abort     = 1'b0;
      pulse     = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic expect_stop(input logic [5:0] val);
      exp_q.push_back({6'(0), cyc[25:0] + 26'd1, val} >> 0);
   endtask

   task automatic configure(input int ppb, input logic wrap, input int hold);
      cfg_ppb     = CNT_W'(ppb);
      cfg_wrap    = wrap;
      cfg_holdoff = HOLD_W'(hold);
   endtask

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      logic [31:0] head;
      if (exp_q.size() > 0 && int'(exp_q[0][31:6]) < cyc) begin
         head = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL stop_missing: got none expected 0x%0h due cycle %0d", head[5:0], head[31:6]);
      end
      if (stop_pulse != '0) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL stop_unexpected: got 0x%0h expected none (cycle %0d)", stop_pulse, cyc);
         end else begin
            head = exp_q.pop_front();
            if (stop_pulse != head[5:0] || int'(head[31:6]) != cyc) begin
               errors++;
               $display("FAIL stop_value: got 0x%0h at cycle %0d expected 0x%0h at cycle %0d",
                        stop_pulse, cyc, head[5:0], head[31:6]);
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      start_rec = 1'b0; abort = 1'b0; pulse = 1'b0;
      configure(1, 1'b0, 0);
      repeat (3) @(posedge clk);
      #1;
      check("reset_stop", int'(stop_pulse), 0);
      check("reset_cur_buf", int'(cur_buf), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_flags", int'({wrapped, dropped}), 0);
      check("reset_state", int'(fsm_state), int'(IDLE));
      reset = 1'b0;
      idle(2);

      // 1: one-shot, one pulse per buffer
      configure(1, 1'b0, 0);
      step(1'b1, 1'b0, 0);
      check("t1_busy", int'(busy), 1);
      for (int i = 0; i < 6; i++) begin
         expect_stop(6'(1 << i));
         step(1'b0, 1'b0, 1'b1);
         idle(3);
      end
      check("t1_done", int'(done), 1);
      check("t1_busy_end", int'(busy), 0);
      check("t1_cur_buf", int'(cur_buf), 5);
      step(1'b0, 1'b0, 1'b1);
      idle(3);
      check("t1_dropped", int'(dropped), 0);

      // 2: ring mode, three pulses per buffer
      configure(3, 1'b1, 0);
      step(1'b1, 1'b0, 0);
      check("t2_restart_done", int'(done), 0);
      for (int k = 1; k <= 21; k++) begin
         if (k % 3 == 0) expect_stop(6'(1 << ((k / 3 - 1) % 6)));
         step(1'b0, 1'b0, 1'b1);
         idle(1);
         if (k == 17) check("t2_wrapped_early", int'(wrapped), 0);
         if (k == 18) begin
            check("t2_cur_buf_wrap", int'(cur_buf), 0);
            check("t2_wrapped", int'(wrapped), 1);
            check("t2_busy", int'(busy), 1);
         end
      end
      check("t2_cur_buf_end", int'(cur_buf), 1);

      // 3: hold-off of 5 cycles
      configure(3, 1'b0, 5);
      step(1'b1, 1'b0, 0);
      check("t3_wrapped_cleared", int'(wrapped), 0);
      for (int c = 0; c <= 6; c++) begin
         step(1'b0, 1'b0, (c == 0 || c == 3 || c == 6));
         if (c == 2) check("t3_dropped_early", int'(dropped), 0);
      end
      check("t3_dropped", int'(dropped), 1);
      check("t3_cur_buf_mid", int'(cur_buf), 0);
      idle(7);
      expect_stop(6'h01);
      step(1'b0, 1'b0, 1'b1);
      idle(2);
      check("t3_cur_buf", int'(cur_buf), 1);

      // 4: pulse coincident with start is ignored
      configure(1, 1'b0, 0);
      step(1'b1, 1'b0, 1'b1);
      idle(2);
      check("t4_cur_buf", int'(cur_buf), 0);
      check("t4_dropped", int'(dropped), 0);
      check("t4_busy", int'(busy), 1);

      // 5: abort cancels a pending strobe, sticky dropped kept
      configure(2, 1'b0, 2);
      step(1'b1, 1'b0, 0);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      check("t5_state", int'(fsm_state), int'(IDLE));
      check("t5_cur_buf", int'(cur_buf), 0);
      check("t5_dropped_kept", int'(dropped), 1);
      step(1'b0, 1'b0, 1'b1);
      idle(2);
      check("t5_idle_pulse_cur_buf", int'(cur_buf), 0);

      // 6: ppb=0 acts as 1; reset mid-run clears everything
      configure(0, 1'b1, 1);
      step(1'b1, 1'b0, 0);
      for (int i = 0; i < 6; i++) begin
         expect_stop(6'(1 << i));
         step(1'b0, 1'b0, 1'b1);
         idle(1);
      end
      check("t6_wrapped", int'(wrapped), 1);
      expect_stop(6'h01);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      check("t6_dropped", int'(dropped), 1);
      check("t6_cur_buf", int'(cur_buf), 1);
      step(1'b0, 1'b0, 1'b1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("t6_reset_stop", int'(stop_pulse), 0);
      check("t6_reset_cur_buf", int'(cur_buf), 0);
      check("t6_reset_status", int'({busy, done, wrapped, dropped}), 0);
      check("t6_reset_state", int'(fsm_state), int'(IDLE));
      reset = 1'b0;
      idle(4);

      check("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/record_buffer_sequencer.md
Name: record_buffer_sequencer

Overview:
- Parametrised successor to the fixed 6-buffer stop-pulse selector in the rangefinder capture path.
- After start_rec it walks an active index across N_BUF record buffers. It issues a one-hot stop pulse to the current buffer once that buffer has received a programmable number of qualified pulses, then advances.
- Adds: configurable depth, pulses-per-buffer, one-shot or ring (wrap) mode, pulse hold-off de-glitching, abort, and status outputs for the SOPC control logic.

Parameters:
- N_BUF, 6, number of record buffers / width of stop_pulse (2..32).
- IDX_W, 3, width of cur_buf; must satisfy 2**IDX_W >= N_BUF.
- CNT_W, 8, width of pulses-per-buffer count.
- HOLD_W, 8, width of hold-off cycle count.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start_rec  in  1  arm/restart the sequence at buffer 0; samples cfg_* inputs.
- abort  in  1  stop sequencing immediately, return to IDLE.
- pulse  in  1  single-cycle event strobe (echo/trigger).
- cfg_ppb  in  CNT_W  pulses per buffer; 0 treated as 1.
- cfg_wrap  in  1  1 = ring mode, 0 = one-shot.
- cfg_holdoff  in  HOLD_W  cycles after an accepted pulse during which pulses are ignored.
- stop_pulse  out  N_BUF  registered one-hot stop strobe, 1 cycle wide.
- cur_buf  out  IDX_W  index of the buffer currently recording.
- busy  out  1  high in state RUN.
- done  out  1  high in state DONE (one-shot complete).
- wrapped  out  1  sticky; set when ring mode returns from N_BUF-1 to 0.
- dropped  out  1  sticky; set when a pulse is ignored by hold-off.

Behaviour:
- Reset: state IDLE; stop_pulse=0, cur_buf=0, busy=0, done=0, wrapped=0, dropped=0; internal counters 0.
- Priority, highest first: reset > abort > start_rec > pulse.
- States:
  - IDLE: start_rec -> RUN.
  - RUN: end of last buffer with cfg_wrap=0 -> DONE; abort -> IDLE; start_rec -> RUN (restart).
  - DONE: start_rec -> RUN; abort -> IDLE.
- Start:
  - On start_rec, latch ppb_q = max(cfg_ppb,1), wrap_q, hold_q.
  - Clear cur_buf, pulse count, hold-off counter, wrapped, dropped.
  - A pulse in the same cycle as start_rec is ignored and not flagged.
  - cfg_* changes after start have no effect until the next start_rec.
- Qualified pulse: pulse=1 in RUN while hold-off counter = 0.
  - Each qualified pulse reloads the hold-off counter with hold_q; the counter decrements to 0 each cycle.
  - With hold_q = 0 every pulse qualifies.
  - A pulse in RUN with counter != 0 sets dropped and is not counted.
  - Pulses in IDLE or DONE are ignored and not flagged.
- Counting: each qualified pulse increments cnt.
  - When cnt+1 = ppb_q: next cycle stop_pulse[cur_buf] = 1 (latency exactly 1 clk after the pulse).
  - In the same edge: cnt <- 0 and cur_buf advances.
- Advance:
  - cur_buf < N_BUF-1: cur_buf+1.
  - cur_buf = N_BUF-1 and wrap_q=1: cur_buf <- 0, wrapped <- 1, stay RUN.
  - cur_buf = N_BUF-1 and wrap_q=0: cur_buf holds, state DONE.
- stop_pulse is never multi-hot and is 0 in every cycle other than the one following a terminal pulse.
- abort or reset mid-sequence:
  - A stop_pulse already registered for the following cycle is suppressed (stop_pulse cleared).
  - cur_buf <- 0; sticky flags are preserved on abort, cleared on reset.
- A restart via start_rec mid-RUN also suppresses any pending stop_pulse.
- Status outputs are registered.

Decomposition:
- Shared package rbs_pkg:
  - state enum {IDLE, RUN, DONE};
  - localparam for default N_BUF;
  - function clog2 for IDX_W checks.
- One natural sub-module: rbs_holdoff.
  - Function: loadable down-counter.
  - Ports: clk, reset, load, load_val, expired.
- Sequencer FSM, pulse counter and one-hot stop decoder stay in the top.

Test Plan:
1. N_BUF=6, ppb=1, wrap=0, holdoff=0; start, then 6 pulses spaced 4 clk -> stop_pulse = 0x01, 0x02, 0x04, 0x08, 0x10, 0x20, each 1 clk after its pulse; done=1; a 7th pulse gives no stop_pulse.
2. ppb=3, wrap=1, 21 pulses -> stop on pulses 3, 6, …, 18 (buffers 0..5); after pulse 18 cur_buf=0 and wrapped=1; pulse 21 -> stop_pulse=0x01.
3. holdoff=5, pulses at cycles 0, 3, 6 after start -> pulse at cycle 3 ignored, dropped=1; cycle 6 counted (cnt=2).
4. start_rec and pulse in the same cycle -> no count, no stop_pulse, dropped=0; cur_buf=0.
5. ppb=1, pulse at cycle t, abort at t+1 -> stop_pulse stays 0 at t+1; state IDLE; cur_buf=0.
6. cfg_ppb=0 -> behaves as ppb=1; reset mid-RUN -> all outputs 0 on the next edge, including wrapped and dropped.
